// File: rtl/sr_bank_arbiter_if.sv
// ---------------------------------------------------------------------------
// sr_bank_arbiter_if
//   Bundle between the control agents and the shared SR bank arbiter.
//   master : agent side (drives clr, req and commands; sees grant/bank state)
//   slave  : arbiter side
//   Signals:
//     clr      bank-wide synchronous clear, active-high
//     req      per-requester request
//     cmd_s    per-requester set bit
//     cmd_r    per-requester reset bit
//     cmd_idx  per-requester bit index, requester i at [i*IDXW +: IDXW]
//     gnt      one-hot grant pulse
//     q        SR bank state
//     busy     a granted command is waiting to be applied
//     err      one-cycle pulse on an illegal / out-of-range command
//     err_id   requester id of the most recent error
// ---------------------------------------------------------------------------
interface sr_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3,
  parameter int IDW   = 2
);
  logic                 clr;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      cmd_s;
  logic [NREQ-1:0]      cmd_r;
  logic [NREQ*IDXW-1:0] cmd_idx;
  logic [NREQ-1:0]      gnt;
  logic [NBITS-1:0]     q;
  logic                 busy;
  logic                 err;
  logic [IDW-1:0]       err_id;

  modport master (
    output clr, req, cmd_s, cmd_r, cmd_idx,
    input  gnt, q, busy, err, err_id
  );

  modport slave (
    input  clr, req, cmd_s, cmd_r, cmd_idx,
    output gnt, q, busy, err, err_id
  );
endinterface

// File: rtl/sr_bank_arbiter.sv
// ---------------------------------------------------------------------------
// sr_bank_arbiter
//   Round-robin arbiter that shares one bank of NBITS SR bits between NREQ
//   requesters. One requester is granted per cycle; its command is captured
//   at the grant edge and applied to the bank on the following edge, so
//   arbitration and apply overlap and a grant per cycle is sustained.
//   Illegal (S=R=1) and out-of-range commands leave the bank untouched and
//   raise a one-cycle err pulse with the offending requester id.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous reset, active-low
//     bus  sr_bank_arbiter_if slave modport (clr, req/cmd in; gnt/q/busy/err out)
// ---------------------------------------------------------------------------
module sr_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3,
  parameter int IDW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  sr_bank_arbiter_if.slave bus
);

  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_s_q, pend_s_d;
  logic             pend_r_q, pend_r_d;
  logic [IDXW-1:0]  pend_idx_q, pend_idx_d;
  logic [IDW-1:0]   pend_id_q, pend_id_d;
  logic [NBITS-1:0] bank_q, bank_d;
  logic             err_q, err_d;
  logic [IDW-1:0]   err_id_q, err_id_d;

  logic [NREQ-1:0]  eligible;
  logic             found;
  logic [IDW-1:0]   win;
  logic             idx_bad;
  logic             cmd_bad;
  logic             write_en;

  // Round-robin search starting at ptr. The current grant holder is masked
  // because it only sees gnt one cycle late and may still be holding req.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_idx;
    eligible = bus.req & ~gnt_q;
    found    = 1'b0;
    win      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_idx = IDW'(cand);
      if (!found && eligible[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
  end

  assign idx_bad  = (32'(pend_idx_q) >= NBITS);
  assign cmd_bad  = pend_s_q & pend_r_q;
  // Only a clean set or reset touches the bank; 00 is a granted no-op.
  assign write_en = pend_vld_q & ~idx_bad & (pend_s_q ^ pend_r_q) & ~bus.clr;

  // Per-bit next state: for a legal write the new value equals the S bit.
  for (genvar gi = 0; gi < NBITS; gi++) begin : g_bit
    assign bank_d[gi] = bus.clr ? 1'b0 :
                        (write_en && (pend_idx_q == IDXW'(gi))) ? pend_s_q :
                        bank_q[gi];
  end

  always_comb begin
    gnt_d      = '0;
    ptr_d      = ptr_q;
    pend_vld_d = 1'b0;
    pend_s_d   = pend_s_q;
    pend_r_d   = pend_r_q;
    pend_idx_d = pend_idx_q;
    pend_id_d  = pend_id_q;
    err_d      = 1'b0;
    err_id_d   = err_id_q;
    // clr discards the pending command and suppresses arbitration entirely.
    if (!bus.clr) begin
      if (pend_vld_q && (idx_bad || cmd_bad)) begin
        err_d    = 1'b1;
        err_id_d = pend_id_q;
      end
      if (found) begin
        gnt_d[win] = 1'b1;
        pend_vld_d = 1'b1;
        pend_s_d   = bus.cmd_s[win];
        pend_r_d   = bus.cmd_r[win];
        pend_idx_d = bus.cmd_idx[win*IDXW +: IDXW];
        pend_id_d  = win;
        ptr_d      = (32'(win) + 1 >= NREQ) ? '0 : win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_q      <= '0;
      ptr_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_s_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      pend_idx_q <= '0;
      pend_id_q  <= '0;
      bank_q     <= '0;
      err_q      <= 1'b0;
      err_id_q   <= '0;
    end else begin
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      pend_vld_q <= pend_vld_d;
      pend_s_q   <= pend_s_d;
      pend_r_q   <= pend_r_d;
      pend_idx_q <= pend_idx_d;
      pend_id_q  <= pend_id_d;
      bank_q     <= bank_d;
      err_q      <= err_d;
      err_id_q   <= err_id_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.q      = bank_q;
  assign bus.busy   = pend_vld_q;
  assign bus.err    = err_q;
  assign bus.err_id = err_id_q;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_sr_bank_arbiter
//   Two arbiters (NBITS=8 and NBITS=6) share one stimulus stream. A
//   behavioural model predicts every cycle's outputs into per-DUT queues;
//   a negedge monitor pops and compares. Directed scenarios run first,
//   followed by randomized requester agents that obey the req/gnt handshake.
// ---------------------------------------------------------------------------
module tb_sr_bank_arbiter;
  localparam int NREQ = 4;
  localparam int IDXW = 3;
  localparam int IDW  = 2;

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic [7:0] q;
    logic       busy;
    logic       err;
    logic [1:0] eid;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clr;
  logic [3:0]  req;
  logic [3:0]  cmd_s;
  logic [3:0]  cmd_r;
  logic [11:0] cmd_idx;

  sr_bank_arbiter_if #(.NREQ(4), .NBITS(8), .IDXW(3), .IDW(2)) bus8 ();
  sr_bank_arbiter_if #(.NREQ(4), .NBITS(6), .IDXW(3), .IDW(2)) bus6 ();

  assign bus8.clr = clr;  assign bus8.req = req;  assign bus8.cmd_s = cmd_s;
  assign bus8.cmd_r = cmd_r;  assign bus8.cmd_idx = cmd_idx;
  assign bus6.clr = clr;  assign bus6.req = req;  assign bus6.cmd_s = cmd_s;
  assign bus6.cmd_r = cmd_r;  assign bus6.cmd_idx = cmd_idx;

  sr_bank_arbiter #(.NREQ(4), .NBITS(8), .IDXW(3), .IDW(2)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8));
  sr_bank_arbiter #(.NREQ(4), .NBITS(6), .IDXW(3), .IDW(2)) dut6 (
    .clk(clk), .rst(rst), .bus(bus6));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb8[$];
  exp_t sb6[$];

  // Reference model state, index 0 = NBITS 8, index 1 = NBITS 6.
  int       m_ptr[2];
  int       m_last[2];   // requester granted at the last edge, -1 if none
  bit       m_pv[2];
  bit       m_ps[2];
  bit       m_pr[2];
  int       m_pidx[2];
  int       m_pid[2];
  bit [7:0] m_bank[2];
  bit       m_err[2];
  int       m_eid[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input int d, output exp_t e);
    int nb;
    int w;
    nb = (d == 0) ? 8 : 6;
    if (!rst) begin
      m_bank[d] = '0; m_ptr[d] = 0; m_last[d] = -1; m_pv[d] = 0;
      m_err[d] = 0; m_eid[d] = 0;
    end else if (clr) begin
      m_bank[d] = '0; m_last[d] = -1; m_pv[d] = 0; m_err[d] = 0;
    end else begin
      m_err[d] = 0;
      if (m_pv[d]) begin
        if (m_pidx[d] >= nb || (m_ps[d] && m_pr[d])) begin
          m_err[d] = 1; m_eid[d] = m_pid[d];
        end else if (m_ps[d]) begin
          m_bank[d][m_pidx[d]] = 1'b1;
        end else if (m_pr[d]) begin
          m_bank[d][m_pidx[d]] = 1'b0;
        end
      end
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr[d] + k) % NREQ;
        if (w < 0 && req[c] && c != m_last[d]) w = c;
      end
      m_last[d] = w;
      if (w >= 0) begin
        m_pv[d]   = 1;
        m_ps[d]   = cmd_s[w];
        m_pr[d]   = cmd_r[w];
        m_pidx[d] = int'(cmd_idx[w*IDXW +: IDXW]);
        m_pid[d]  = w;
        m_ptr[d]  = (w + 1) % NREQ;
      end else begin
        m_pv[d] = 0;
      end
    end
    e.cyc  = cyc + 1;
    e.gnt  = (m_last[d] >= 0) ? 4'(1 << m_last[d]) : 4'b0;
    e.q    = m_bank[d];
    e.busy = m_pv[d];
    e.err  = m_err[d];
    e.eid  = 2'(m_eid[d]);
  endtask

  // Predict the coming edge, then let it happen; returns 1ns after the edge.
  task automatic tick();
    exp_t e;
    model_step(0, e); sb8.push_back(e);
    model_step(1, e); sb6.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input bit s, input bit r, input int idx);
    cmd_s[i] = s;
    cmd_r[i] = r;
    cmd_idx[i*IDXW +: IDXW] = 3'(idx);
  endtask

  exp_t e8, e6;
  always @(negedge clk) begin
    if (sb8.size() > 0 && sb8[0].cyc <= cyc) begin
      e8 = sb8.pop_front();
      check("sb8_gnt",  32'(bus8.gnt),    32'(e8.gnt));
      check("sb8_q",    32'(bus8.q),      32'(e8.q));
      check("sb8_busy", 32'(bus8.busy),   32'(e8.busy));
      check("sb8_err",  32'(bus8.err),    32'(e8.err));
      check("sb8_eid",  32'(bus8.err_id), 32'(e8.eid));
      if (e8.gnt != 0 || e8.err)
        $display("cyc=%0d gnt=%b q8=%h err8=%b eid8=%0d", cyc, bus8.gnt, bus8.q, bus8.err, bus8.err_id);
    end
    if (sb6.size() > 0 && sb6[0].cyc <= cyc) begin
      e6 = sb6.pop_front();
      check("sb6_gnt",  32'(bus6.gnt),    32'(e6.gnt));
      check("sb6_q",    32'(bus6.q),      32'(e6.q));
      check("sb6_busy", 32'(bus6.busy),   32'(e6.busy));
      check("sb6_err",  32'(bus6.err),    32'(e6.err));
      check("sb6_eid",  32'(bus6.err_id), 32'(e6.eid));
    end
  end

  initial begin
    rst = 1'b0; clr = 1'b0; req = 4'b1111;
    cmd_s = '0; cmd_r = '0; cmd_idx = '0;

    // Reset held for two edges with everyone requesting.
    tick(); tick();
    check("rst_q",    32'(bus8.q),    32'h00);
    check("rst_gnt",  32'(bus8.gnt),  32'h0);
    check("rst_busy", 32'(bus8.busy), 32'h0);
    check("rst_err",  32'(bus8.err),  32'h0);
    rst = 1'b1;
    tick();
    check("first_gnt", 32'(bus8.gnt), 32'b0001);
    req = '0;
    tick(); tick();

    // Single set then reset of bit 5 by requester 2.
    set_cmd(2, 1, 0, 5); req = 4'b0100;
    tick();
    check("set_gnt", 32'(bus8.gnt), 32'b0100);
    req = '0;
    tick();
    check("set_q", 32'(bus8.q), 32'h20);
    set_cmd(2, 0, 1, 5); req = 4'b0100;
    tick();
    req = '0;
    tick();
    check("reset_q", 32'(bus8.q), 32'h00);

    // Round-robin fairness from a fresh pointer.
    rst = 1'b0; tick(); rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1, 0, i);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_gnt", 32'(bus8.gnt), 32'(1 << (k % 4)));
    end
    check("rr_q", 32'(bus8.q), 32'h0F);
    req = '0;
    tick();

    // Illegal S=R=1 and out-of-range commands.
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_q", 32'(bus8.q), 32'h00);
    set_cmd(0, 1, 0, 3); req = 4'b0001; tick(); req = '0; tick();
    check("pre_ill_q", 32'(bus8.q), 32'h08);
    set_cmd(1, 1, 1, 3); req = 4'b0010; tick(); req = '0; tick();
    check("ill_q",   32'(bus8.q),      32'h08);
    check("ill_err", 32'(bus8.err),    32'h1);
    check("ill_eid", 32'(bus8.err_id), 32'h1);
    tick();
    check("ill_err_pulse", 32'(bus8.err),    32'h0);
    check("ill_eid_hold",  32'(bus8.err_id), 32'h1);
    set_cmd(2, 1, 0, 7); req = 4'b0100; tick(); req = '0; tick();
    check("oor6_err", 32'(bus6.err),    32'h1);
    check("oor6_eid", 32'(bus6.err_id), 32'h2);
    check("oor6_q",   32'(bus6.q),      32'h08);
    check("oor8_q",   32'(bus8.q),      32'h88);

    // clr arrives while a grant is pending.
    set_cmd(3, 1, 0, 0); req = 4'b1000;
    tick();
    check("clrc_gnt",  32'(bus8.gnt),  32'b1000);
    check("clrc_busy", 32'(bus8.busy), 32'h1);
    req = '0; clr = 1'b1;
    tick();
    check("clrc_q",    32'(bus8.q),    32'h00);
    check("clrc_err",  32'(bus8.err),  32'h0);
    check("clrc_busy0", 32'(bus8.busy), 32'h0);
    clr = 1'b0;
    tick();
    check("clrc_q_after",   32'(bus8.q),   32'h00);
    check("clrc_err_after", 32'(bus8.err), 32'h0);

    // Reset aborts a pending command and returns the pointer to 0.
    set_cmd(1, 1, 0, 1); req = 4'b0010;
    tick();
    check("rmid_busy", 32'(bus8.busy), 32'h1);
    rst = 1'b0; req = '0;
    tick();
    check("rmid_q",    32'(bus8.q),    32'h00);
    check("rmid_busy0", 32'(bus8.busy), 32'h0);
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_cmd(i, 0, 0, 0);
    req = 4'b1111;
    tick();
    check("rmid_gnt", 32'(bus8.gnt), 32'b0001);
    req = '0;
    tick();

    // Randomized agents: hold req+command until gnt, then drop or re-request.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && bus8.gnt[i]) begin
          if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
          else set_cmd(i, 1'($urandom), 1'($urandom), int'($urandom_range(7, 0)));
        end else if (!req[i] && $urandom_range(9, 0) < 4) begin
          set_cmd(i, 1'($urandom), 1'($urandom), int'($urandom_range(7, 0)));
          req[i] = 1'b1;
        end
      end
      clr = ($urandom_range(49, 0) == 0);
      rst = ($urandom_range(99, 0) != 0);
      tick();
    end

    rst = 1'b1; clr = 1'b0; req = '0;
    tick(); tick();
    @(negedge clk);
    #1;
    check("sb8_drained", 32'(sb8.size()), 32'h0);
    check("sb6_drained", 32'(sb6.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_bank_arbiter.md
Name: sr_bank_arbiter

Overview:
Round-robin arbiter and sequencer that shares one bank of NBITS SR flip-flop bits between NREQ requesters. Each requester presents a set/reset command for one bit index with a req/gnt handshake. The arbiter grants one requester per cycle, applies the winning command to the bank one cycle later, and flags illegal S=R=1 and out-of-range commands instead of driving an undefined value. It sits between control agents and the shared SR status/flag bank.

Parameters:
NREQ, 4, number of requesters (2..8)
NBITS, 8, number of SR bits in the bank
IDXW, 3, width of a bit index (clog2(NBITS), min 1)
IDW, 2, width of a requester id (clog2(NREQ), min 1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low
clr  input  1  synchronous clear of whole bank, active-high
req  input  NREQ  per-requester request
cmd_s  input  NREQ  per-requester set bit
cmd_r  input  NREQ  per-requester reset bit
cmd_idx  input  NREQ*IDXW  per-requester bit index, requester i at [i*IDXW +: IDXW]
gnt  output  NREQ  one-hot grant, one-cycle pulse
q  output  NBITS  SR bank state
busy  output  1  a granted command is pending application
err  output  1  one-cycle pulse: illegal or out-of-range command applied
err_id  output  IDW  requester id of last error, holds until next error

Behaviour:
- Reset: rst sampled low at an edge gives q=0, gnt=0, busy=0, err=0, err_id=0, rr pointer=0, pending command cleared. Reset wins over everything and aborts any pending command mid-operation.
- Arbitration at edge E (rst high, clr low):
  - Eligible set = req with the bit of the requester currently holding gnt masked off. A requester sees gnt one cycle late, so this prevents a double grant.
  - Winner w = first eligible index searching ptr, ptr+1, ... with wrap modulo NREQ.
  - After E: gnt = one-hot(w), pending = {cmd_s[w], cmd_r[w], idx[w], id=w}, busy=1, ptr = (w+1) mod NREQ.
  - No eligible requester: gnt=0, ptr unchanged.
- Apply at edge E+1, for a pending command:
  - {s,r}=00: q unchanged (granted no-op).
  - 01: q[idx]=0.
  - 10: q[idx]=1.
  - 11: q unchanged; err=1 for one cycle; err_id=id.
  - idx >= NBITS: q unchanged; err=1; err_id=id, regardless of s/r.
  - busy clears unless a new grant is issued at the same edge.
- Pipelining: arbitration and apply run in the same cycle. One grant per cycle is sustained; latency is req sampled at E, gnt high E..E+1, q updated at E+1.
- Handshake: requester holds req and command stable until it samples gnt=1. It may drop req, or keep it for a new request that becomes eligible one cycle after gnt falls. The command is captured at the grant edge; later changes do not affect it.
- clr high at an edge (rst high): q=0, pending command discarded (no apply, no err), gnt=0, busy=0, no arbitration that cycle, ptr unchanged.
- err is a single-cycle pulse. Back-to-back errors give err high on consecutive cycles, with err_id updated each cycle.
- Gnt is always one-hot or zero; never more than one bit set.

Test Plan:
- Reset: rst=0 for 2 edges with req=4'b1111 -> q=8'h00, gnt=0, busy=0, err=0. Release rst; first grant is gnt=4'b0001.
- Single set/reset: req[2]=1, s=1, r=0, idx=5 -> gnt=4'b0100 one cycle, q=8'h20 next edge. Then s=0, r=1, idx=5 -> q=8'h00.
- Round-robin fairness: req=4'b1111 held continuously, each requester sets its own idx=i -> gnt sequence 0001, 0010, 0100, 1000, 0001 (repeat). Each grant is a single cycle, no requester granted on two consecutive cycles, q reaches 8'h0F.
- Illegal and out-of-range: req[1] with s=r=1, idx=3 (q=8'h08 before) -> q stays 8'h08, err pulse, err_id=1. NBITS=6 build with idx=7 -> err, q unchanged.
- clr collision: grant to req[3] (s=1, idx=0) issued at E, clr=1 at E+1 -> q=8'h00, no err, busy=0, and the command is never applied.
- Reset mid-operation: grant pending (busy=1), rst=0 at next edge -> q=0, busy=0, ptr=0. The next grant comes from requester 0 if it is requesting.
